// File: rtl/spi_rx_sample_fifo.sv
// Purpose: FWFT receive buffer between the SPI master stage and the AXI register/DMA consumer.
// Latency: a word pushed into an empty FIFO appears on m_data/m_valid one cycle after the capture edge.
// Backpressure: the input has none; a word arriving while full with no pop is dropped and counted in overflow/ovf_count.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET    clock and asynchronous active-high reset
//   in_data, in_valid           completed SPI word and its one-cycle strobe
//   clear, ovf_clr              synchronous flush of contents / clear of overflow status
//   m_data, m_valid, m_ready    head-of-FIFO valid/ready stream
//   level, empty, full, wm_irq  registered fill status
//   overflow, ovf_count         sticky drop flag and saturating drop counter
module spi_rx_sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int WATERMARK  = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  clear,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  wm_irq,
    output logic                  overflow,
    output logic [7:0]            ovf_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LVL_WM  = WATERMARK[DEPTH_LOG2:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr_n, rd_ptr_n;
    logic [DEPTH_LOG2:0]   level_n;
    logic [DATA_WIDTH-1:0] head_n;
    logic                  push, pop, drop;

    always_comb begin
        // clear outranks everything: nothing is popped, pushed or dropped that cycle.
        pop  = m_valid && m_ready && !clear;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts.
        push = in_valid && !clear && (!full || pop);
        drop = in_valid && !clear && full && !pop;

        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        level_n  = level;
        if (clear) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            level_n  = '0;
        end else begin
            if (push) wr_ptr_n = wr_ptr + 1'b1;
            if (pop)  rd_ptr_n = rd_ptr + 1'b1;
            if (push && !pop)      level_n = level + 1'b1;
            else if (pop && !push) level_n = level - 1'b1;
        end

        // m_data is registered; when the incoming word becomes the new head it
        // has not reached the array yet, so forward it directly.
        if (push && (wr_ptr == rd_ptr_n)) head_n = in_data;
        else                              head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            wm_irq    <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            level   <= level_n;
            empty   <= (level_n == '0);
            full    <= (level_n == LVL_MAX);
            wm_irq  <= (level_n >= LVL_WM);
            m_valid <= (level_n != '0);
            m_data  <= head_n;

            // A drop in the same cycle as ovf_clr restarts the count at one.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clr)                 ovf_count <= 8'd1;
                else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
            end else if (ovf_clr) begin
                overflow  <= 1'b0;
                ovf_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_sample_fifo.sv
// Purpose: randomized and directed check of spi_rx_sample_fifo against a queue-based model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: m_ready driven by the bench, including stalls long enough to force overflow.
module tb_spi_rx_sample_fifo;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESET;
    logic [15:0] in_data;
    logic        in_valid;
    logic        clear;
    logic        ovf_clr;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        wm_irq;
    logic        overflow;
    logic [7:0]  ovf_count;

    int total = 0;
    int bad   = 0;

    // Reference model: word queue plus overflow status.
    logic [15:0] mq[$];
    int          m_ovf;
    int          m_cnt;

    spi_rx_sample_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(4), .WATERMARK(8)) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .clear        (clear),
        .ovf_clr      (ovf_clr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .wm_irq       (wm_irq),
        .overflow     (overflow),
        .ovf_count    (ovf_count)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ":level"},  32'(level),     32'(mq.size()));
        check_val({tag, ":empty"},  32'(empty),     32'(mq.size() == 0));
        check_val({tag, ":full"},   32'(full),      32'(mq.size() == 16));
        check_val({tag, ":wm"},     32'(wm_irq),    32'(mq.size() >= 8));
        check_val({tag, ":valid"},  32'(m_valid),   32'(mq.size() != 0));
        check_val({tag, ":ovf"},    32'(overflow),  32'(m_ovf));
        check_val({tag, ":ovfcnt"}, 32'(ovf_count), 32'(m_cnt));
        if (mq.size() != 0) check_val({tag, ":head"}, 32'(m_data), 32'(mq[0]));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare.
    task automatic cyc(input logic iv, input logic [15:0] d, input logic rdy,
                       input logic clr, input logic oclr, input string tag);
        bit p, w, dr;
        in_valid = iv;
        in_data  = d;
        m_ready  = rdy;
        clear    = clr;
        ovf_clr  = oclr;
        @(posedge S_AXI_ACLK);
        p  = (mq.size() != 0) && rdy && !clr;
        w  = iv && !clr && ((mq.size() < 16) || p);
        dr = iv && !clr && (mq.size() == 16) && !p;
        if (clr) mq.delete();
        else begin
            if (p) void'(mq.pop_front());
            if (w) mq.push_back(d);
        end
        if (dr) begin
            m_ovf = 1;
            m_cnt = oclr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (oclr) begin
            m_ovf = 0;
            m_cnt = 0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ":level"},  32'(level),     32'd0);
        check_val({tag, ":empty"},  32'(empty),     32'd1);
        check_val({tag, ":full"},   32'(full),      32'd0);
        check_val({tag, ":valid"},  32'(m_valid),   32'd0);
        check_val({tag, ":wm"},     32'(wm_irq),    32'd0);
        check_val({tag, ":ovf"},    32'(overflow),  32'd0);
        check_val({tag, ":ovfcnt"}, 32'(ovf_count), 32'd0);
        check_val({tag, ":data"},   32'(m_data),    32'd0);
    endtask

    logic [15:0] exp_w;

    initial begin
        S_AXI_ARESET = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        m_ready  = 1'b0;
        clear    = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("rst_async");
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESET = 1'b0;
        check_reset_outputs("rst_hold");

        // Single word
        cyc(1, 16'hA5C3, 0, 0, 0, "single_push");
        check_val("single_data", 32'(m_data), 32'hA5C3);
        check_val("single_lvl",  32'(level),  32'd1);
        cyc(0, 16'h0, 1, 0, 0, "single_pop");
        check_val("single_gone", 32'(m_valid), 32'd0);
        cyc(0, 16'h0, 1, 0, 0, "empty_ready");

        // Fill and order, watermark on the way up
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 16'(i), 0, 0, 0, "fill");
            check_val("fill_wm", 32'(wm_irq), 32'(i >= 8));
        end
        check_val("fill_full", 32'(full), 32'd1);

        // Overflow with no pop
        for (int i = 0; i < 3; i++) cyc(1, 16'hDEAD, 0, 0, 0, "ovf_drop");
        check_val("ovf_cnt3", 32'(ovf_count), 32'd3);
        check_val("ovf_flag", 32'(overflow),  32'd1);
        for (int i = 1; i <= 16; i++) begin
            check_val("drain_order", 32'(m_data), 32'(i));
            cyc(0, 16'h0, 1, 0, 0, "drain");
            check_val("drain_wm", 32'(wm_irq), 32'((16 - i) >= 8));
        end
        cyc(0, 16'h0, 0, 0, 1, "ovf_clr");
        check_val("ovf_clr_cnt", 32'(ovf_count), 32'd0);

        // Simultaneous push and pop at full
        for (int i = 1; i <= 16; i++) cyc(1, 16'(i), 0, 0, 0, "fill2");
        cyc(1, 16'hBEEF, 1, 0, 0, "full_pushpop");
        check_val("fpp_level", 32'(level),    32'd16);
        check_val("fpp_ovf",   32'(overflow), 32'd0);
        check_val("fpp_head",  32'(m_data),   32'd2);
        // Drop beats ovf_clr in the same cycle
        cyc(1, 16'hDEAD, 0, 0, 0, "drop_a");
        cyc(1, 16'hDEAD, 0, 0, 0, "drop_b");
        cyc(1, 16'hDEAD, 0, 0, 1, "drop_clr");
        check_val("drop_wins_cnt", 32'(ovf_count), 32'd1);
        check_val("drop_wins_ovf", 32'(overflow),  32'd1);
        for (int i = 2; i <= 17; i++) begin
            exp_w = (i == 17) ? 16'hBEEF : 16'(i);
            check_val("drain2_order", 32'(m_data), 32'(exp_w));
            cyc(0, 16'h0, 1, 0, 0, "drain2");
        end

        // Pointer wrap with continuous pop
        for (int i = 0; i < 20; i++) begin
            cyc(1, 16'h0100 + 16'(i), 1, 0, 0, "wrap");
            check_val("wrap_head", 32'(m_data), 32'h0100 + 32'(i));
        end
        cyc(1, 16'h0200, 0, 0, 0, "wrap_more");
        cyc(1, 16'h0201, 0, 0, 0, "wrap_more");
        check_val("wrap_lvl3", 32'(level), 32'd3);
        cyc(1, 16'h1234, 1, 1, 0, "clear");
        check_val("clear_lvl",   32'(level),     32'd0);
        check_val("clear_valid", 32'(m_valid),   32'd0);
        check_val("clear_cnt",   32'(ovf_count), 32'd1);
        cyc(0, 16'h0, 1, 0, 0, "post_clear");
        cyc(1, 16'h0055, 0, 0, 0, "post_clear_push");
        check_val("post_clear_head", 32'(m_data), 32'h0055);
        cyc(0, 16'h0, 1, 0, 0, "post_clear_pop");

        // Randomized traffic with phase-dependent consumer speed
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            case ((i / 250) % 4)
                0: rdy_pct = 90;
                1: rdy_pct = 10;
                2: rdy_pct = 50;
                default: rdy_pct = 0;
            endcase
            cyc($urandom_range(0, 99) < 60, 16'($urandom),
                $urandom_range(0, 99) < rdy_pct,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 2, "rand");
        end

        // Asynchronous reset mid-stream
        cyc(0, 16'h0, 0, 1, 0, "pre_rst_clear");
        for (int i = 0; i < 5; i++) cyc(1, 16'h0300 + 16'(i), 0, 0, 0, "pre_rst");
        check_val("pre_rst_lvl", 32'(level), 32'd5);
        #2;
        S_AXI_ARESET = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("rst_mid");
        #1;
        S_AXI_ARESET = 1'b0;
        cyc(1, 16'h0077, 0, 0, 0, "post_rst_push");
        check_val("post_rst_lvl",  32'(level),  32'd1);
        check_val("post_rst_head", 32'(m_data), 32'h0077);

        in_valid = 1'b0;
        m_ready  = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rx_sample_fifo.md
Name: spi_rx_sample_fifo

Overview:
- Receive-side buffer directly downstream of the SPI master stage.
- Captures each completed 16-bit SPI word on its single-cycle `drdy`-style strobe.
- Stores words in a small first-word-fall-through FIFO and presents them on a valid/ready stream to the AXI register/DMA consumer.
- Reports fill level, watermark, and overflow so no sample is lost silently when the consumer stalls.

Parameters:
- DATA_WIDTH, 16, width of one SPI word.
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth = 16 words).
- WATERMARK, 8, level at or above which wm_irq asserts; legal range 1..2**DEPTH_LOG2.

Ports:
- S_AXI_ACLK  in  1  system clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  completed SPI word from the master stage.
- in_valid  in  1  one-cycle strobe; in_data is valid in that cycle; no backpressure.
- clear  in  1  synchronous flush of the FIFO contents.
- ovf_clr  in  1  synchronous clear of overflow and ovf_count.
- m_data  out  DATA_WIDTH  head-of-FIFO word.
- m_valid  out  1  m_data holds a valid word.
- m_ready  in  1  consumer accepts the word.
- level  out  DEPTH_LOG2+1  number of words stored (0..2**DEPTH_LOG2).
- empty  out  1  level == 0.
- full  out  1  level == 2**DEPTH_LOG2.
- wm_irq  out  1  level >= WATERMARK.
- overflow  out  1  sticky flag: at least one word was dropped.
- ovf_count  out  8  number of dropped words, saturating at 255.

Behaviour:
- Reset: one clock and an asynchronous, active-high reset (S_AXI_ACLK, S_AXI_ARESET). On reset assertion, immediately and independent of the clock:
  - pointers and level = 0; empty = 1; full = 0; m_valid = 0; wm_irq = 0; overflow = 0; ovf_count = 0; m_data = 0.
  - A reset mid-stream discards all stored words.
- Storage: DATA_WIDTH x 2**DEPTH_LOG2 array; wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth. level is a registered counter, not derived from the pointers.
- Push: in_valid=1 and full=0 writes in_data at wr_ptr and increments wr_ptr.
- Pop: m_valid=1 and m_ready=1 increments rd_ptr.
- FWFT timing:
  - m_data = mem[rd_ptr]; m_valid = !empty, driven from a register.
  - A push into an empty FIFO at edge N gives m_valid=1 with that word on m_data in the cycle after edge N (1-cycle latency).
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - m_data is meaningful only when m_valid=1; the bench does not check it otherwise.
- Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with simultaneous pop: a push in the same cycle is accepted because the pop frees a slot. level stays at max, full stays 1, and there is no overflow.
- Full without pop: in_valid drops the word; memory and pointers are unchanged. overflow is set to 1 and ovf_count increments, saturating at 255.
- Empty with m_ready=1: no pop occurs and there is no underflow; the pointers are unchanged.
- clear=1:
  - Next edge: wr_ptr = rd_ptr = 0, level = 0, m_valid = 0.
  - clear has priority over push and pop in the same cycle. An in_valid word in that cycle is discarded and does NOT count as an overflow.
  - overflow and ovf_count are not affected by clear.
- ovf_clr=1: next edge sets overflow = 0 and ovf_count = 0. If a drop occurs in the same cycle, the drop wins: overflow = 1, ovf_count = 1.
- Flag timing: empty, full, and wm_irq are all registered and updated on the same edge as level, so they stay consistent with level in every cycle.
- Pointer wrap: after 2**DEPTH_LOG2 pushes, wr_ptr returns to 0. Data order is preserved across the wrap.

Test Plan:
- Single word: after reset, push 16'hA5C3 → m_valid=1 one cycle later, m_data=A5C3, level=1. With m_ready=1 → m_valid=0, empty=1, level=0.
- Fill and order: push 0x0001..0x0010 with m_ready=0 → full=1, level=16, wm_irq=1 from the 8th push onward. Then drain with m_ready=1 → the 16 words come out in order, and wm_irq drops when level reaches 7.
- Overflow: with the FIFO full, push 0xDEAD three times with no pop → overflow=1, ovf_count=3, the contents are unchanged, and the drain returns 0x0001..0x0010. Pulse ovf_clr → overflow=0, ovf_count=0.
- Simultaneous at full: full FIFO, in_valid=1 with 0xBEEF and m_ready=1 in the same cycle → 0x0001 is popped, 0xBEEF is accepted as the last word, level=16, overflow stays 0.
- Clear priority and wrap: push 20 words while popping to force pointer wrap, and verify FIFO order. Then assert clear together with in_valid=0x1234 → level=0, m_valid=0, ovf_count unchanged, and 0x1234 never appears.
- Async reset mid-stream: with level=5, assert S_AXI_ARESET between clock edges → all outputs reach reset values immediately without a clock edge. After release, the first push appears alone at level=1.
